// File: rtl/data_mem_port.sv
// rtl/data_mem_port.sv - multi-cycle word-addressed data memory with stall request
// Operands are captured at acceptance; the write or read capture happens on the edge entering DONE.
module data_mem_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_stall,
  output logic              busy,
  output logic              range_err,
  output logic              proto_err,
  output logic [15:0]       stall_cycles
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic              req;
  logic              complete, eff_rd, eff_wr, eff_in_rng;
  logic [15:0]       eff_addr;
  logic [DATA_W-1:0] eff_wdata;
  logic              range_err_q, proto_err_q;

  assign req        = mem_read | mem_write;
  assign eff_in_rng = (eff_addr >> ADDR_W) == 16'd0;
  assign range_err  = range_err_q;
  assign proto_err  = proto_err_q;

  // RAM is never cleared; an access abandoned by reset must not commit.
  always_ff @(posedge clk) begin
    if (!rst && complete && eff_wr && eff_in_rng)
      ram_q[eff_addr[ADDR_W-1:0]] <= eff_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else if (complete) begin
      if (!eff_in_rng)
        range_err_q <= 1'b1;
      if (eff_rd && eff_wr)
        proto_err_q <= 1'b1;
    end
  end

  generate
    if (LATENCY == 0) begin : g_lat0
      assign complete     = req;
      assign eff_rd       = mem_read;
      assign eff_wr       = mem_write;
      assign eff_addr     = addr;
      assign eff_wdata    = wdata;
      assign rdata        = (mem_read && eff_in_rng) ? ram_q[addr[ADDR_W-1:0]] : '0;
      assign mem_stall    = 1'b0;
      assign busy         = 1'b0;
      assign stall_cycles = 16'd0;
    end else begin : g_fsm
      localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

      typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

      state_t            state_q, state_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic              stall;
      logic              op_rd_q, op_wr_q;
      logic [15:0]       addr_q, stall_cnt_q;
      logic [DATA_W-1:0] wdata_q, rdata_q;

      // WAIT lasts LATENCY-1 cycles: leave when the decrement reaches zero.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
          S_IDLE: begin
            if (req) begin
              stall   = 1'b1;
              cnt_d   = CNT_W'(LATENCY - 1);
              state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
            end
          end
          S_WAIT: begin
            stall = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
              state_d = S_DONE;
          end
          S_DONE:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end

      assign complete  = (state_d == S_DONE) && (state_q != S_DONE);
      assign eff_rd    = (state_q == S_IDLE) ? mem_read  : op_rd_q;
      assign eff_wr    = (state_q == S_IDLE) ? mem_write : op_wr_q;
      assign eff_addr  = (state_q == S_IDLE) ? addr      : addr_q;
      assign eff_wdata = (state_q == S_IDLE) ? wdata     : wdata_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          op_rd_q     <= 1'b0;
          op_wr_q     <= 1'b0;
          addr_q      <= '0;
          wdata_q     <= '0;
          rdata_q     <= '0;
          stall_cnt_q <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          if (state_q == S_IDLE && req) begin
            op_rd_q <= mem_read;
            op_wr_q <= mem_write;
            addr_q  <= addr;
            wdata_q <= wdata;
          end
          if (complete && eff_rd && !eff_wr)
            rdata_q <= eff_in_rng ? ram_q[eff_addr[ADDR_W-1:0]] : '0;
          if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
      end

      assign rdata        = rdata_q;
      assign mem_stall    = stall;
      assign busy         = (state_q != S_IDLE);
      assign stall_cycles = stall_cnt_q;
    end
  endgenerate
endmodule

// File: tb/tb_data_mem_port.sv
// tb/tb_data_mem_port.sv - directed bench for data_mem_port at LATENCY 0, 1, 2 and 250
// Transaction-level model of each instance checked every cycle, plus literal spot checks.
module tb_data_mem_port;
  localparam int LAT [4] = '{0, 1, 2, 250};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       mr, mw, stl, bsy, rerr, perr;
  logic [3:0][15:0] ad, wd, rdat, sc;

  logic [3:0]       e_stl, e_bsy, e_re, e_pe;
  logic [3:0][15:0] e_rd, e_sc;
  logic [15:0]      mem_m [4][256];
  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  data_mem_port #(.DATA_W(16), .ADDR_W(8), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .mem_read(mr[0]), .mem_write(mw[0]), .addr(ad[0]), .wdata(wd[0]),
    .rdata(rdat[0]), .mem_stall(stl[0]), .busy(bsy[0]), .range_err(rerr[0]),
    .proto_err(perr[0]), .stall_cycles(sc[0]));
  data_mem_port #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_read(mr[1]), .mem_write(mw[1]), .addr(ad[1]), .wdata(wd[1]),
    .rdata(rdat[1]), .mem_stall(stl[1]), .busy(bsy[1]), .range_err(rerr[1]),
    .proto_err(perr[1]), .stall_cycles(sc[1]));
  data_mem_port #(.DATA_W(16), .ADDR_W(8), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .mem_read(mr[2]), .mem_write(mw[2]), .addr(ad[2]), .wdata(wd[2]),
    .rdata(rdat[2]), .mem_stall(stl[2]), .busy(bsy[2]), .range_err(rerr[2]),
    .proto_err(perr[2]), .stall_cycles(sc[2]));
  data_mem_port #(.DATA_W(16), .ADDR_W(8), .LATENCY(250)) u_l250 (
    .clk(clk), .rst(rst), .mem_read(mr[3]), .mem_write(mw[3]), .addr(ad[3]), .wdata(wd[3]),
    .rdata(rdat[3]), .mem_stall(stl[3]), .busy(bsy[3]), .range_err(rerr[3]),
    .proto_err(perr[3]), .stall_cycles(sc[3]));

  function automatic void chk(string nm, int d, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] sat(logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // Effect of one completed access on the model.
  function automatic void apply(int d);
    logic inr = (ad[d][15:8] == 8'd0);
    if (mw[d]) begin
      if (inr) mem_m[d][ad[d][7:0]] = wd[d];
    end else if (mr[d] && LAT[d] > 0) begin
      e_rd[d] = inr ? mem_m[d][ad[d][7:0]] : 16'h0;
    end
    if (!inr) e_re[d] = 1'b1;
    if (mr[d] && mw[d]) e_pe[d] = 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      chk("rdata", d, rdat[d], e_rd[d]);
      chk("mem_stall", d, {15'd0, stl[d]}, {15'd0, e_stl[d]});
      chk("busy", d, {15'd0, bsy[d]}, {15'd0, e_bsy[d]});
      chk("range_err", d, {15'd0, rerr[d]}, {15'd0, e_re[d]});
      chk("proto_err", d, {15'd0, perr[d]}, {15'd0, e_pe[d]});
      chk("stall_cycles", d, sc[d], e_sc[d]);
    end
  end

  task automatic reset_exp();
    for (int d = 0; d < 4; d++) begin
      mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = 16'h0; wd[d] = 16'h0;
      e_rd[d] = 16'h0; e_sc[d] = 16'h0;
      e_stl[d] = 1'b0; e_bsy[d] = 1'b0; e_re[d] = 1'b0; e_pe[d] = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
  task automatic access(int d, bit rd, bit wr, logic [15:0] a, logic [15:0] w);
    int lat = LAT[d];
    mr[d] = rd; mw[d] = wr; ad[d] = a; wd[d] = w;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (e_stl[d]) e_sc[d] = sat(e_sc[d]);
        if (k == lat) apply(d);
      end
      e_stl[d] = (k < lat);
      e_bsy[d] = (k > 0);
      if (lat == 0) e_rd[d] = (rd && a[15:8] == 8'd0) ? mem_m[d][a[7:0]] : 16'h0;
    end
    @(posedge clk); #1;
    if (lat == 0) apply(d);
  endtask

  task automatic idle(int d, int n);
    mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = 16'h0; wd[d] = 16'h0;
    e_stl[d] = 1'b0; e_bsy[d] = 1'b0;
    if (LAT[d] == 0) e_rd[d] = 16'h0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 256; i++) mem_m[d][i] = 16'h0;
    reset_exp();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("lit_reset_rdata", 2, rdat[2], 16'h0);
    chk("lit_reset_sc", 2, sc[2], 16'h0);

    // LATENCY=2 store then load back-to-back
    access(2, 0, 1, 16'h0005, 16'hBEEF);
    access(2, 1, 0, 16'h0005, 16'h0);
    chk("lit_l2_rdata", 2, rdat[2], 16'hBEEF);
    chk("lit_l2_sc", 2, sc[2], 16'd4);
    idle(2, 1);

    // LATENCY=0 back-to-back stores and loads
    access(0, 0, 1, 16'h0010, 16'h1234);
    access(0, 0, 1, 16'h0011, 16'h5678);
    access(0, 1, 0, 16'h0010, 16'h0);
    access(0, 1, 0, 16'h0011, 16'h0);
    mr[0] = 1'b1; ad[0] = 16'h0010; e_rd[0] = 16'h1234;
    #1 chk("lit_l0_rdata", 0, rdat[0], 16'h1234);
    @(posedge clk); #1;
    idle(0, 1);
    chk("lit_l0_sc", 0, sc[0], 16'h0);

    // Out-of-range store/load; RAM[0] must survive
    access(2, 0, 1, 16'h0000, 16'h5555);
    access(2, 0, 1, 16'h0100, 16'hAAAA);
    chk("lit_range_err", 2, {15'd0, rerr[2]}, 16'd1);
    access(2, 1, 0, 16'h0100, 16'h0);
    chk("lit_oor_rdata", 2, rdat[2], 16'h0);
    access(2, 1, 0, 16'h0000, 16'h0);
    chk("lit_ram0", 2, rdat[2], 16'h5555);
    idle(2, 1);

    // Simultaneous read+write on LATENCY=1
    access(1, 0, 1, 16'h0003, 16'h0F0F);
    access(1, 1, 0, 16'h0003, 16'h0);
    access(1, 1, 1, 16'h0003, 16'h00FF);
    chk("lit_proto_err", 1, {15'd0, perr[1]}, 16'd1);
    chk("lit_proto_rdata", 1, rdat[1], 16'h0F0F);
    access(1, 1, 0, 16'h0003, 16'h0);
    chk("lit_proto_ram", 1, rdat[1], 16'h00FF);
    idle(1, 1);

    // Request dropped during WAIT still completes with latched operands
    mw[2] = 1'b1; ad[2] = 16'h0020; wd[2] = 16'h3333; e_stl[2] = 1'b1; e_bsy[2] = 1'b0;
    @(posedge clk); #1;
    e_sc[2] = sat(e_sc[2]);
    mw[2] = 1'b0; ad[2] = 16'h0; wd[2] = 16'h0; e_bsy[2] = 1'b1;
    @(posedge clk); #1;
    e_sc[2] = sat(e_sc[2]);
    mem_m[2][8'h20] = 16'h3333; e_stl[2] = 1'b0;
    @(posedge clk); #1;
    access(2, 1, 0, 16'h0020, 16'h0);
    chk("lit_drop_rdata", 2, rdat[2], 16'h3333);

    // Reset in the middle of a store
    access(2, 0, 1, 16'h0007, 16'h1111);
    mw[2] = 1'b1; ad[2] = 16'h0007; wd[2] = 16'h2222; e_stl[2] = 1'b1; e_bsy[2] = 1'b0;
    @(posedge clk); #1;
    e_sc[2] = sat(e_sc[2]); e_bsy[2] = 1'b1;
    rst = 1'b1;
    reset_exp();
    #1;
    chk("lit_rst_stall", 2, {15'd0, stl[2]}, 16'd0);
    chk("lit_rst_busy", 2, {15'd0, bsy[2]}, 16'd0);
    chk("lit_rst_rdata", 2, rdat[2], 16'h0);
    @(posedge clk); #1 rst = 1'b0;
    access(2, 1, 0, 16'h0007, 16'h0);
    chk("lit_rst_ram", 2, rdat[2], 16'h1111);
    idle(2, 1);

    // Stall counter saturation on the long-latency instance
    for (int i = 0; i < 263; i++)
      access(3, 0, 1, 16'h0000, 16'(i));
    idle(3, 2);
    chk("lit_sat", 3, sc[3], 16'hFFFF);
    access(3, 1, 0, 16'h0000, 16'h0);
    idle(3, 1);
    chk("lit_sat_hold", 3, sc[3], 16'hFFFF);
    chk("lit_sat_rdata", 3, rdat[3], 16'd262);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
